// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg : shared types and defaults for the UART boot controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package boot_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } boot_state_t;

  localparam int BOOT_ADDR_W      = 14;
  localparam int BOOT_TIMEOUT_CYC = 1000000;

endpackage

`default_nettype wire

// File: rtl/uart_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_boot_ctrl_if : UART byte stream in, imem write port and CPU control out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_boot_ctrl_if import boot_pkg::*; #(
  parameter int ADDR_W = BOOT_ADDR_W
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              skip_load;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              uart_over;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output rx_valid, rx_data, skip_load, reload,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, uart_over, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, skip_load, reload,
    output imem_we, imem_addr, imem_wdata, cpu_hold, uart_over, load_error, words_loaded
  );

endinterface

`default_nettype wire

// File: rtl/boot_word_packer.sv
// ---------------------------------------------------------------------------
// boot_word_packer : packs bytes LSB-first into 32-bit words, XOR checksum
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module boot_word_packer (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_clr,
  input  wire logic        i_byte_en,
  input  wire logic [7:0]  i_byte,
  output logic      [1:0]  o_byte_idx,
  output logic      [7:0]  o_checksum,
  output logic      [31:0] o_word,
  output logic             o_word_ready
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_acc;
  logic [31:0] r_word;
  logic [7:0]  r_chk;
  logic        r_word_ready;

  // r_word is only loaded on a completed word so it holds while no write is pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_idx   <= 2'd0;
      r_acc        <= '0;
      r_word       <= '0;
      r_chk        <= '0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      if (i_clr) begin
        r_byte_idx <= 2'd0;
        r_acc      <= '0;
        r_chk      <= '0;
      end else if (i_byte_en) begin
        r_chk      <= r_chk ^ i_byte;
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0: r_acc[7:0]   <= i_byte;
          2'd1: r_acc[15:8]  <= i_byte;
          2'd2: r_acc[23:16] <= i_byte;
          default: begin
            r_word       <= {i_byte, r_acc};
            r_word_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_byte_idx   = r_byte_idx;
  assign o_checksum   = r_chk;
  assign o_word       = r_word;
  assign o_word_ready = r_word_ready;

endmodule

`default_nettype wire

// File: rtl/uart_boot_ctrl.sv
// ---------------------------------------------------------------------------
// uart_boot_ctrl : loads a UART program image into imem, then releases the CPU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_boot_ctrl import boot_pkg::*; #(
  parameter int ADDR_W      = BOOT_ADDR_W,
  parameter int TIMEOUT_CYC = BOOT_TIMEOUT_CYC
) (
  input wire logic        clk,
  input wire logic        reset,
  uart_boot_ctrl_if.slave bus
);

  localparam int                LEN_W     = ADDR_W + 1;
  localparam int                TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;

  boot_state_t       r_state;
  boot_state_t       w_next;
  logic [7:0]        r_len_lo;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [TO_W-1:0]   r_to;
  logic              r_cpu_hold;
  logic              r_uart_over;
  logic              r_load_error;

  logic [1:0]        w_byte_idx;
  logic [7:0]        w_chk;
  logic [31:0]       w_word;
  logic              w_word_ready;
  logic [15:0]       w_len16;
  logic [LEN_W-1:0]  w_words_inc;
  logic              w_byte_en;
  logic              w_word_done;
  logic              w_last_word;
  logic              w_timeout;
  logic              w_reload;
  logic              w_counting;

  assign w_len16     = {bus.rx_data, r_len_lo};
  assign w_words_inc = r_words + LEN_ONE;
  assign w_byte_en   = (r_state == DATA) && bus.rx_valid;
  assign w_word_done = w_byte_en && (w_byte_idx == 2'd3);
  assign w_last_word = w_word_done && (w_words_inc == r_len);
  assign w_timeout   = (r_to == TO_LAST) && !bus.rx_valid;
  assign w_reload    = bus.reload && ((r_state == DONE) || (r_state == ERROR));
  assign w_counting  = (r_state == LEN_HI) || (r_state == DATA) || (r_state == CHK);

  boot_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_reload),
    .i_byte_en    (w_byte_en),
    .i_byte       (bus.rx_data),
    .o_byte_idx   (w_byte_idx),
    .o_checksum   (w_chk),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LEN_LO;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LEN_LO: begin
        if (bus.skip_load)     w_next = DONE;
        else if (bus.rx_valid) w_next = LEN_HI;
      end
      LEN_HI: begin
        if (bus.rx_valid) begin
          if (w_len16 == 16'd0)                w_next = CHK;
          else if (32'(w_len16) > MAX_WORDS)   w_next = ERROR;
          else                                 w_next = DATA;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      DATA: begin
        if (w_last_word)    w_next = CHK;
        else if (w_timeout) w_next = ERROR;
      end
      CHK: begin
        if (bus.rx_valid)   w_next = (bus.rx_data == w_chk) ? DONE : ERROR;
        else if (w_timeout) w_next = ERROR;
      end
      DONE, ERROR: begin
        if (bus.reload) w_next = LEN_LO;
      end
      default: w_next = LEN_LO;
    endcase
  end

  // Status flags follow the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_lo     <= '0;
      r_len        <= '0;
      r_words      <= '0;
      r_addr       <= '0;
      r_to         <= '0;
      r_cpu_hold   <= 1'b1;
      r_uart_over  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_cpu_hold   <= (w_next != DONE);
      r_uart_over  <= (w_next == DONE);
      r_load_error <= (w_next == ERROR);

      if ((r_state == LEN_LO) && bus.rx_valid) r_len_lo <= bus.rx_data;
      if ((r_state == LEN_HI) && bus.rx_valid) r_len    <= LEN_W'(w_len16);

      if (w_reload) begin
        r_words <= '0;
      end else if (w_word_done) begin
        r_words <= w_words_inc;
        r_addr  <= r_words[ADDR_W-1:0];
      end

      if ((w_next != r_state) || bus.rx_valid) r_to <= '0;
      else if (w_counting)                     r_to <= r_to + TO_ONE;
    end
  end

  assign bus.imem_we      = w_word_ready;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = w_word;
  assign bus.cpu_hold     = r_cpu_hold;
  assign bus.uart_over    = r_uart_over;
  assign bus.load_error   = r_load_error;
  assign bus.words_loaded = r_words;

endmodule

`default_nettype wire
